compute_sequencer: RTL and testbench
====================================

Name: compute_sequencer

Overview:
- Array-side responder to the systolic controller's compute handshake.
- Detects a compute request on start_compute and latches the 5-bit instruction.
- Drives skewed operand-feed, accumulate and result-drain strobes into the 4x4 PE grid and its operand/result buffers.
- Returns a one-cycle systolic_array_done pulse so the controller leaves COMPUTE.

Parameters:
- N, 4, array dimension (rows = cols = N).
- CW, $clog2(2*N), width of feed_cnt.
- RW, $clog2(N), width of res_row.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_compute  in  1  level request from the controller; high while the controller is in COMPUTE.
- instruction_i  in  5  instruction from the controller; sampled only on the request edge.
- systolic_array_done  out  1  one-cycle completion pulse to the controller.
- busy  out  1  high from CLEAR through DONE inclusive.
- acc_clr  out  1  PE accumulator clear strobe.
- acc_en  out  1  PE accumulate enable.
- lane_valid  out  N  bit i = row-i A lane and column-i B lane carry data this cycle.
- feed_cnt  out  CW  feed time index t; lane i reads buffer element k = t - i.
- res_valid  out  1  result row read strobe.
- res_row  out  RW  result row index.

Behaviour:
- Reset (rst=0, async): state=IDLE, instr_q=0, start_q=0, cnt=0. All outputs 0.
- Request edge: start_compute=1 && start_q=0, where start_q is start_compute registered every cycle. Let c be the cycle the edge is seen.
  - Latch instr_q = instruction_i.
  - No new request is accepted until start_compute has been seen low.
- Decode of instr_q:
  - [1:0]=01 MATMUL.
  - [1:0]=10 DRAIN_ONLY.
  - [1:0]=00 or 11 NOP.
  - [2] acc_keep: suppresses acc_clr.
  - [4:3] reserved, ignored.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- MATMUL timing:
  - c+1 CLEAR: acc_clr = ~acc_keep.
  - c+2..c+2N FEED (2N-1 cycles): feed_cnt = t = 0..2N-2; acc_en=1; lane_valid[i] = (i <= t <= i+N-1).
  - c+2N+1..c+3N-1 FLUSH (N-1 cycles): acc_en=1, lane_valid=0, feed_cnt holds 0.
  - c+3N..c+4N-1 DRAIN: res_valid=1, res_row = 0..N-1.
  - c+4N DONE: systolic_array_done=1 for exactly one cycle, then IDLE.
  - N=4: done at c+16.
- DRAIN_ONLY timing: c+1..c+N DRAIN, DONE at c+N+1. No acc_clr, no acc_en.
- NOP timing: DONE at c+1. This guarantees the controller never hangs on instruction 0 or reserved opcodes.
- All outputs are registered and decoded from state/cnt. Counter cnt resets to 0 on every state change.
- Abort: start_compute=0 in any state other than IDLE or DONE returns to IDLE next cycle.
  - No done pulse.
  - All strobes drop that same next cycle.
- Back-to-back requests: the controller holds start_compute low for one cycle (its DONE state) and re-raises it. This is a new edge and restarts at CLEAR with no extra dead cycles.
- start_compute held high through and after done: no restart; stay in IDLE until a low-then-high edge.
- instruction_i changes mid-operation: ignored.

Test Plan:
- Reset mid-FEED: rst low during FEED -> all outputs 0 immediately (async). After release, stays IDLE until a new edge.
- MATMUL, N=4, instruction 5'b00001, start rising at c:
  - acc_clr at c+1.
  - lane_valid = 0001, 0011, 0111, 1111, 1110, 1100, 1000 over c+2..c+8.
  - acc_en c+2..c+11.
  - res_row 0..3 over c+12..c+15.
  - Single done at c+16.
- instruction 5'b00101 (acc_keep): same timing as above, acc_clr never asserted.
- instruction 5'b00000 and 5'b00011: done at c+1, every other strobe stays 0. instruction 5'b00010: res_row 0..3 over c+1..c+4, done at c+5.
- Back-to-back: after done, start low for 1 cycle then high with 5'b00001 -> second full sequence with a done 17 cycles after the first (16 for the sequence plus the 1-cycle gap). start held high with no low cycle -> no second run.
- Abort: start drops at c+5 -> IDLE at c+6, no done. Next edge at c+9 -> fresh CLEAR at c+10.

Source files
------------

// File: rtl/compute_sequencer.sv
// rtl/compute_sequencer.sv - array-side compute handshake responder for the N x N systolic grid
module compute_sequencer #(
   parameter int N  = 4,
   parameter int CW = $clog2(2*N),
   parameter int RW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_compute,
   input  logic [4:0]    instruction_i,
   output logic          systolic_array_done,
   output logic          busy,
   output logic          acc_clr,
   output logic          acc_en,
   output logic [N-1:0]  lane_valid,
   output logic [CW-1:0] feed_cnt,
   output logic          res_valid,
   output logic [RW-1:0] res_row
);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;

   localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(N-2);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(N-1);

   state_t        state;
   state_t        nxt_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt_cnt;
   logic [4:0]    instr_q;
   logic [4:0]    nxt_instr;
   logic          start_q;
   logic          req;
   logic [N-1:0]  lane_mask;

   always_comb begin
      req       = start_compute && !start_q;
      nxt_instr = instr_q;
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      case (state)
         IDLE: begin
            if (req) begin
               nxt_instr = instruction_i;
               case (instruction_i[1:0])
                  2'b01:   nxt_state = CLEAR;
                  2'b10:   nxt_state = DRAIN;
                  default: nxt_state = DONE;
               endcase
            end
         end
         CLEAR:   nxt_state = FEED;
         FEED:    if (cnt == FEED_LAST)  nxt_state = FLUSH;
         FLUSH:   if (cnt == FLUSH_LAST) nxt_state = DRAIN;
         DRAIN:   if (cnt == DRAIN_LAST) nxt_state = DONE;
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
      // Controller leaving COMPUTE mid-operation aborts without a done pulse.
      if (!start_compute && state != IDLE && state != DONE)
         nxt_state = IDLE;
      if (nxt_state != state || nxt_state == IDLE)
         nxt_cnt = '0;
   end

   // Lane i carries element k = t - i, valid only while 0 <= k <= N-1.
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < N; i++)
         lane_mask[i] = (nxt_state == FEED) && (int'(nxt_cnt) >= i) && (int'(nxt_cnt) <= i + N - 1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         instr_q             <= '0;
         start_q             <= 1'b0;
         systolic_array_done <= 1'b0;
         busy                <= 1'b0;
         acc_clr             <= 1'b0;
         acc_en              <= 1'b0;
         lane_valid          <= '0;
         feed_cnt            <= '0;
         res_valid           <= 1'b0;
         res_row             <= '0;
      end else begin
         state               <= nxt_state;
         cnt                 <= nxt_cnt;
         instr_q             <= nxt_instr;
         start_q             <= start_compute;
         systolic_array_done <= (nxt_state == DONE);
         busy                <= (nxt_state != IDLE);
         acc_clr             <= (nxt_state == CLEAR) && !nxt_instr[2];
         acc_en              <= (nxt_state == FEED) || (nxt_state == FLUSH);
         lane_valid          <= lane_mask;
         feed_cnt            <= (nxt_state == FEED) ? nxt_cnt : '0;
         res_valid           <= (nxt_state == DRAIN);
         res_row             <= (nxt_state == DRAIN) ? nxt_cnt[RW-1:0] : '0;
      end
   end

endmodule

// File: tb/tb_compute_sequencer.sv
// tb/tb_compute_sequencer.sv - randomized bench for compute_sequencer against a cycle-offset model
module tb_compute_sequencer;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int RW = 2;

   logic          clk;
   logic          rst;
   logic          start_compute;
   logic [4:0]    instruction_i;
   logic          systolic_array_done;
   logic          busy;
   logic          acc_clr;
   logic          acc_en;
   logic [N-1:0]  lane_valid;
   logic [CW-1:0] feed_cnt;
   logic          res_valid;
   logic [RW-1:0] res_row;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done_cyc = -1;

   compute_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst), .start_compute(start_compute), .instruction_i(instruction_i),
      .systolic_array_done(systolic_array_done), .busy(busy), .acc_clr(acc_clr), .acc_en(acc_en),
      .lane_valid(lane_valid), .feed_cnt(feed_cnt), .res_valid(res_valid), .res_row(res_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] observed();
      return {systolic_array_done, busy, acc_clr, acc_en, lane_valid, feed_cnt, res_valid, res_row};
   endfunction

   function automatic int done_off(input logic [4:0] ins);
      if (ins[1:0] == 2'b01) return 4*N;
      if (ins[1:0] == 2'b10) return N+1;
      return 1;
   endfunction

   // Expected outputs k cycles after the request edge, straight from the timing table.
   function automatic logic [13:0] model(input logic [4:0] ins, input int k);
      logic d, b, clr, en, rv;
      logic [N-1:0] lv;
      int fc, rr;
      d = 0; b = 0; clr = 0; en = 0; rv = 0; lv = '0; fc = 0; rr = 0;
      if (ins[1:0] == 2'b01) begin
         b   = (k >= 1 && k <= 4*N);
         clr = (k == 1) && !ins[2];
         if (k >= 2 && k <= 2*N) begin
            fc = k - 2;
            en = 1;
            for (int i = 0; i < N; i++) lv[i] = (fc >= i && fc <= i + N - 1);
         end
         if (k > 2*N && k < 3*N) en = 1;
         if (k >= 3*N && k < 4*N) begin rv = 1; rr = k - 3*N; end
         d = (k == 4*N);
      end else if (ins[1:0] == 2'b10) begin
         b = (k >= 1 && k <= N+1);
         if (k >= 1 && k <= N) begin rv = 1; rr = k - 1; end
         d = (k == N+1);
      end else begin
         b = (k == 1);
         d = (k == 1);
      end
      return {d, b, clr, en, lv, CW'(fc), rv, RW'(rr)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input int k, input logic [13:0] exp);
      logic [13:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Raises start in the current cycle (start was low in the previous one) and checks every cycle.
   task automatic run_op(input string tag, input logic [4:0] ins, input int abort_a, input bit b2b);
      int d, last;
      logic [13:0] exp;
      d = done_off(ins);
      last = (abort_a > 0) ? abort_a + 4 : (b2b ? d + 1 : d + 4);
      last_done_cyc = -1;
      start_compute = 1'b1;
      instruction_i = ins;
      for (int k = 1; k <= last; k++) begin
         step();
         if (k == abort_a) start_compute = 1'b0;
         if (b2b && k == d) start_compute = 1'b0;
         if (!b2b && abort_a == 0 && k == d + 3) start_compute = 1'b0;
         instruction_i = 5'($urandom);
         exp = (abort_a > 0 && k > abort_a) ? 14'h0 : model(ins, k);
         if (systolic_array_done) last_done_cyc = cyc;
         check(tag, k, exp);
      end
   endtask

   initial begin
      int d1;
      logic [4:0] ins;
      int ab;
      rst = 1'b1;
      start_compute = 1'b0;
      instruction_i = 5'd0;
      #2 rst = 1'b0;
      #1 check("reset_async", 0, 14'h0);
      step();
      step();
      check("reset_hold", 0, 14'h0);
      rst = 1'b1;
      step();
      check("idle_after_reset", 0, 14'h0);

      run_op("matmul", 5'b00001, 0, 0);
      run_op("matmul_keep", 5'b00101, 0, 0);
      run_op("nop0", 5'b00000, 0, 0);
      run_op("nop3", 5'b00011, 0, 0);
      run_op("drain_only", 5'b00010, 0, 0);
      run_op("reserved_bits", 5'b11001, 0, 0);

      run_op("b2b_first", 5'b00001, 0, 1);
      d1 = last_done_cyc;
      run_op("b2b_second", 5'b00001, 0, 0);
      checks++;
      assert (last_done_cyc - d1 === 17) else begin
         errors++;
         $error("FAIL b2b_gap observed=%0d expected=17", last_done_cyc - d1);
      end

      run_op("abort", 5'b00001, 5, 0);
      run_op("after_abort", 5'b00001, 0, 0);

      // Async reset in the middle of FEED.
      start_compute = 1'b1;
      instruction_i = 5'b00001;
      for (int k = 1; k <= 4; k++) step();
      check("pre_reset_feed", 4, model(5'b00001, 4));
      #1 rst = 1'b0;
      start_compute = 1'b0;
      #1 check("reset_mid_feed", 4, 14'h0);
      step();
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check("idle_post_reset", k, 14'h0);
      end

      for (int n = 0; n < 25; n++) begin
         ins = 5'($urandom);
         ab = 0;
         if (done_off(ins) > 1 && ($urandom % 3) == 0)
            ab = int'($urandom_range(1, done_off(ins) - 1));
         run_op("random", ins, ab, 1'($urandom));
      end
      step();
      check("final_idle", 0, 14'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
